// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes ALU-class RISC-V instructions and writes them sequentially into instruction memory.
// Optional ENC_ILLEGAL_OP_EN rejects illegal ops with an err pulse instead of writing a NOP.
module instr_encoder_loader #(
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [11:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    state_t state, state_nx;
    logic [AW-1:0] wr_ptr;
    logic [AW:0] count_inc;
    logic [2:0] funct3;
    logic [31:0] word;
    logic legal, take, accept, reject;
    always_comb begin
        legal = op[3] ? (op == 4'b1000 || op == 4'b1010 || op == 4'b1011 || op == 4'b1100)
                      : (op[2:0] <= 3'd4);
        funct3 = op[2:0] == 3'b010 ? 3'b111 :
                 op[2:0] == 3'b011 ? 3'b110 :
                 op[2:0] == 3'b100 ? 3'b010 : 3'b000;
        word = op[3] ? {imm, rs1, funct3, rd, 7'b0010011}
                     : {op == 4'b0001 ? 7'b0100000 : 7'b0000000, rs2, rs1, funct3, rd, 7'b0110011};
        take = state == IDLE && in_valid && !clear;
`ifdef ENC_ILLEGAL_OP_EN
        accept = take && legal;
        reject = take && !legal;
`else
        // Illegal ops are written as the canonical NOP (ADDI x0,x0,0).
        if (!legal)
            word = 32'h0000_0013;
        accept = take;
        reject = 1'b0;
`endif
        count_inc = count + 1'b1;
        state_nx = clear ? IDLE :
                   accept ? WRITE :
                   state == WRITE ? (count_inc == FULL_COUNT ? FULL : IDLE) : state;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            count     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                count  <= '0;
            end else if (state == WRITE) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count_inc;
            end
            if (accept) begin
                mem_addr  <= wr_ptr;
                mem_wdata <= word;
            end
        end
    end
`ifdef ENC_ILLEGAL_OP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else
            err <= reject;
    end
`else
    assign err = 1'b0;
    logic unused_reject;
    assign unused_reject = reject;
`endif
    // Decoded from registered state so reset drops the strobe without an edge.
    assign in_ready = state == IDLE;
    assign mem_we   = state == WRITE;
    assign full     = count == FULL_COUNT;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: scoreboard bench for instr_encoder_loader; expected writes are queued at stimulus time.
module tb_instr_encoder_loader;
    logic clock = 0, reset = 1, clear = 0, in_valid = 0;
    logic [3:0] op = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic [11:0] imm = 0;
    logic in_ready, mem_we, full, err;
    logic [3:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0] count;
    logic [35:0] exp_q[$], obs_q[$];
    logic [3:0] ptr_m = 0;
    logic [4:0] cnt_m = 0;
    int total = 0, bad = 0;

    instr_encoder_loader dut (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .full(full), .err(err)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});

    function automatic logic [31:0] enc(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [11:0] i);
        case (o)
            4'b0000: return {7'h00, s2, s1, 3'b000, d, 7'h33};
            4'b0001: return {7'h20, s2, s1, 3'b000, d, 7'h33};
            4'b0010: return {7'h00, s2, s1, 3'b111, d, 7'h33};
            4'b0011: return {7'h00, s2, s1, 3'b110, d, 7'h33};
            4'b0100: return {7'h00, s2, s1, 3'b010, d, 7'h33};
            4'b1000: return {i, s1, 3'b000, d, 7'h13};
            4'b1010: return {i, s1, 3'b111, d, 7'h13};
            4'b1011: return {i, s1, 3'b110, d, 7'h13};
            4'b1100: return {i, s1, 3'b010, d, 7'h13};
            default: return 32'h0000_0013;
        endcase
    endfunction

    task automatic push(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [11:0] i, input logic [31:0] w);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = i; in_valid = 1;
        exp_q.push_back({ptr_m, w});
        ptr_m++; cnt_m++;
        @(negedge clock);
        in_valid = 0;
        op = 4'hx; rd = 5'hx; rs1 = 5'hx; rs2 = 5'hx; imm = 12'hx;
    endtask

    task automatic drain(input string name);
        @(negedge clock); @(negedge clock);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s_nwrites: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [35:0] o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL %s_write: got addr=%0d data=%h required addr=%0d data=%h",
                         name, o[35:32], o[31:0], e[35:32], e[31:0]);
            end
        end
        obs_q.delete(); exp_q.delete();
        total++;
        if (count !== cnt_m) begin
            bad++;
            $display("FAIL %s_count: got %0d required %0d", name, count, cnt_m);
        end
    endtask

    task automatic do_clear;
        @(negedge clock); clear = 1;
        @(negedge clock); clear = 0;
        ptr_m = 0; cnt_m = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, count, full, err} !== {1'b1, 1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals: rdy=%b we=%b addr=%0d data=%h cnt=%0d full=%b err=%b required 1 0 0 0 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, count, full, err);
        end
        reset = 0;
    endtask

    task automatic test_add;
        push(4'b0000, 5'd3, 5'd1, 5'd2, 12'h0, 32'h002081B3);
        total++;
        if ({mem_we, in_ready} !== 2'b10) begin
            bad++;
            $display("FAIL add_write_cycle: we,rdy=%b required 10", {mem_we, in_ready});
        end
        drain("add");
    endtask

    task automatic test_sub_addi;
        do_clear();
        push(4'b0001, 5'd5, 5'd6, 5'd7, 12'h0, 32'h407302B3);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL sub_ready: got %b required 0", in_ready); end
        push(4'b1000, 5'd1, 5'd0, 5'd9, 12'hFFF, 32'hFFF00093);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL addi_ready: got %b required 0", in_ready); end
        drain("sub_addi");
    endtask

    task automatic test_back_to_back;
        logic [3:0] ops[5] = '{4'b0010, 4'b0011, 4'b0100, 4'b1010, 4'b1011};
        for (int k = 0; k < 5; k++) begin
            logic [4:0] d, s1, s2;
            logic [11:0] i;
            d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom); i = 12'($urandom);
            push(ops[k], d, s1, s2, i, enc(ops[k], d, s1, s2, i));
        end
        drain("b2b");
    endtask

    task automatic test_fill;
        do_clear();
        op = 4'b1100; rd = 5'd4; rs1 = 5'd1; rs2 = 5'd0; imm = 12'd5; in_valid = 1;
        for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), 32'h0050A213});
        cnt_m = 16; ptr_m = 0;
        repeat (36) @(negedge clock);
        total++;
        if ({full, in_ready, count} !== {1'b1, 1'b0, 5'd16}) begin
            bad++;
            $display("FAIL fill_state: full=%b rdy=%b cnt=%0d required 1 0 16", full, in_ready, count);
        end
        drain("fill");
    endtask

    task automatic test_clear_full;
        @(negedge clock); clear = 1; in_valid = 1;
        @(negedge clock); clear = 0; in_valid = 0;
        ptr_m = 0; cnt_m = 0;
        total++;
        if ({count, in_ready, full, mem_we} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL clear_full: cnt=%0d rdy=%b full=%b we=%b required 0 1 0 0", count, in_ready, full, mem_we);
        end
        drain("clear_noaccept");
        push(4'b0000, 5'd3, 5'd1, 5'd2, 12'h0, 32'h002081B3);
        drain("after_clear");
    endtask

    task automatic test_illegal;
`ifdef ENC_ILLEGAL_OP_EN
        op = 4'b1001; rd = 5'd5; rs1 = 5'd6; rs2 = 5'd7; imm = 12'h123; in_valid = 1;
        @(negedge clock); in_valid = 0;
        total++;
        if ({err, mem_we, in_ready} !== 3'b101) begin
            bad++;
            $display("FAIL illegal_err: err,we,rdy=%b required 101", {err, mem_we, in_ready});
        end
        @(negedge clock);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL illegal_pulse: err=%b required 0", err); end
        drain("illegal");
`else
        push(4'b1001, 5'd5, 5'd6, 5'd7, 12'h123, 32'h0000_0013);
        drain("illegal_nop");
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL illegal_err_tied: err=%b required 0", err); end
`endif
    endtask

    task automatic test_reset_mid_write;
        @(negedge clock); op = 4'b0000; rd = 5'd1; rs1 = 5'd1; rs2 = 5'd1; in_valid = 1;
        @(posedge clock); #2 in_valid = 0;
        total++;
        if (mem_we !== 1'b1) begin bad++; $display("FAIL midwrite_we_high: got %b required 1", mem_we); end
        reset = 1;
        #1;
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, count, full, err} !== {1'b1, 1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midwrite_reset: rdy=%b we=%b addr=%0d data=%h cnt=%0d full=%b err=%b required 1 0 0 0 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, count, full, err);
        end
        @(negedge clock); reset = 0;
        ptr_m = 0; cnt_m = 0;
        obs_q.delete();
        push(4'b1000, 5'd2, 5'd3, 5'd0, 12'h7FF, enc(4'b1000, 5'd2, 5'd3, 5'd0, 12'h7FF));
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_addi();
        test_back_to_back();
        test_fill();
        test_clear_full();
        test_illegal();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
